slug_ctrl: RTL and testbench

//  Game-level sequencer for the slug sprite datapath (slug_mod position counters).

---
 rtl/slug_ctrl_pkg.sv | 29 ++
 rtl/slug_ctrl_frame_timer.sv | 34 +++
 rtl/slug_ctrl.sv | 165 ++++++++++++++++
 tb/tb_slug_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/slug_ctrl_pkg.sv
// Shared encodings and default geometry for the slug game sequencer.
package slug_ctrl_pkg;

  localparam int unsigned POS_W          = 15;
  localparam int unsigned SCORE_W        = 8;
  localparam int unsigned LIVES_W        = 2;

  localparam int unsigned V_TOP_DEF      = 16;
  localparam int unsigned V_BOT_DEF      = 464;
  localparam int unsigned H_EXIT_DEF     = 0;
  localparam int unsigned LIVES_INIT_DEF = 3;
  localparam int unsigned HIT_FRAMES_DEF = 60;

  localparam int unsigned FLASH_PERIOD   = 8;
  localparam int unsigned FLASH_W        = $clog2(FLASH_PERIOD + 1);

  // Speedup divider: N runs 4..1, one step per EXITS_PER_STEP safe exits
  localparam int unsigned DIV_W          = 3;
  localparam int unsigned EXITS_PER_STEP = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_RESPAWN = 3'd2,
    ST_HIT     = 3'd3,
    ST_OVER    = 3'd4
  } state_e;

endpackage

// File: rtl/slug_ctrl_frame_timer.sv
// Frame-pulse counter: counts ticks, strobes and wraps on the term_i-th tick.
module slug_ctrl_frame_timer #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         tick_i,
  input  logic [W-1:0] term_i,
  output logic         tc_c_o
);

  logic [W-1:0] count_q, count_d;

  // >= so a term lowered mid-count still wraps on the next tick
  always_comb begin
    tc_c_o  = tick_i && !clr_i && (count_q >= (term_i - W'(1)));
    count_d = count_q;
    if (clr_i || tc_c_o) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/slug_ctrl.sv
// Game-level sequencer driving slug_mod controls, score, lives and hit blink.
// Optional SLUG_CTRL_SPEEDUP_EN: leftEN on every Nth frame, N shrinking with score.
module slug_ctrl
  import slug_ctrl_pkg::*;
#(
  parameter int unsigned V_TOP      = V_TOP_DEF,
  parameter int unsigned V_BOT      = V_BOT_DEF,
  parameter int unsigned H_EXIT     = H_EXIT_DEF,
  parameter int unsigned LIVES_INIT = LIVES_INIT_DEF,
  parameter int unsigned HIT_FRAMES = HIT_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Frame,
  input  logic               start,
  input  logic               btnU,
  input  logic               btnD,
  input  logic               collision,
  input  logic [POS_W-1:0]   SlugH,
  input  logic [POS_W-1:0]   SlugV,
  output logic               UP,
  output logic               DW,
  output logic               leftEN,
  output logic               INIT,
  output logic               flash,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over
);

  localparam int unsigned HIT_W = $clog2(HIT_FRAMES + 1);

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic                 flash_q, flash_d;
  logic                 in_hit;
  logic                 hit_done_c;
  logic                 flash_tc_c;
  logic                 move_left_c;

  assign in_hit = (state_q == ST_HIT);

  slug_ctrl_frame_timer #(.W(HIT_W)) u_hit_timer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (!in_hit),
    .tick_i (Frame && in_hit),
    .term_i (HIT_W'(HIT_FRAMES)),
    .tc_c_o (hit_done_c)
  );

  slug_ctrl_frame_timer #(.W(FLASH_W)) u_flash_timer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (!in_hit),
    .tick_i (Frame && in_hit),
    .term_i (FLASH_W'(FLASH_PERIOD)),
    .tc_c_o (flash_tc_c)
  );

`ifdef SLUG_CTRL_SPEEDUP_EN
  logic [DIV_W-1:0] div_n_c;

  // N derives from score, which clears in IDLE together with the divider
  always_comb begin
    if (score_q >= SCORE_W'(3 * EXITS_PER_STEP)) begin
      div_n_c = DIV_W'(1);
    end else if (score_q >= SCORE_W'(2 * EXITS_PER_STEP)) begin
      div_n_c = DIV_W'(2);
    end else if (score_q >= SCORE_W'(EXITS_PER_STEP)) begin
      div_n_c = DIV_W'(3);
    end else begin
      div_n_c = DIV_W'(4);
    end
  end

  slug_ctrl_frame_timer #(.W(DIV_W)) u_div_timer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_q == ST_IDLE),
    .tick_i (Frame && (state_q == ST_RUN)),
    .term_i (div_n_c),
    .tc_c_o (move_left_c)
  );
`else
  assign move_left_c = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      score_q <= '0;
      lives_q <= LIVES_W'(LIVES_INIT);
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lives_q <= lives_d;
      flash_q <= flash_d;
    end
  end

  // Next state plus same-cycle control decode
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    lives_d   = lives_q;
    flash_d   = flash_q;
    UP        = 1'b0;
    DW        = 1'b0;
    leftEN    = 1'b0;
    INIT      = 1'b0;
    game_over = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        INIT    = 1'b1;
        score_d = '0;
        lives_d = LIVES_W'(LIVES_INIT);
        flash_d = 1'b0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        leftEN = move_left_c;
        UP     = btnU && !btnD && (SlugV > POS_W'(V_TOP));
        DW     = btnD && !btnU && (SlugV < POS_W'(V_BOT));
        if (collision) begin
          if (lives_q <= LIVES_W'(1)) begin
            state_d = ST_OVER;
            lives_d = '0;
          end else begin
            state_d = ST_HIT;
            lives_d = lives_q - LIVES_W'(1);
            flash_d = 1'b1;
          end
        end else if (Frame && (SlugH == POS_W'(H_EXIT))) begin
          state_d = ST_RESPAWN;
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
        end
      end
      ST_RESPAWN: begin
        INIT    = 1'b1;
        state_d = ST_RUN;
      end
      ST_HIT: begin
        if (hit_done_c) begin
          state_d = ST_RESPAWN;
          flash_d = 1'b0;
        end else if (flash_tc_c) begin
          flash_d = !flash_q;
        end
      end
      ST_OVER: begin
        game_over = 1'b1;
        if (start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign flash = flash_q;
  assign score = score_q;
  assign lives = lives_q;

endmodule

// File: tb/tb_slug_ctrl.sv
// Directed scoreboard bench for slug_ctrl (default build, speedup disabled).
module tb_slug_ctrl;

  logic        clk = 1'b0;
  logic        reset, Frame, start, btnU, btnD, collision;
  logic [14:0] SlugH, SlugV;
  logic        UP, DW, leftEN, INIT, flash, game_over;
  logic [7:0]  score;
  logic [1:0]  lives;

  int checks = 0;
  int errors = 0;

  string       tag_q[$];
  logic [15:0] exp_q[$];

  slug_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .Frame     (Frame),
    .start     (start),
    .btnU      (btnU),
    .btnD      (btnD),
    .collision (collision),
    .SlugH     (SlugH),
    .SlugV     (SlugV),
    .UP        (UP),
    .DW        (DW),
    .leftEN    (leftEN),
    .INIT      (INIT),
    .flash     (flash),
    .score     (score),
    .lives     (lives),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ev(input bit up, input bit dw, input bit le, input bit ini,
                                     input bit fl, input bit go, input logic [1:0] lv,
                                     input logic [7:0] sc);
    return {up, dw, le, ini, fl, go, lv, sc};
  endfunction

  function automatic logic [15:0] run_v(input logic [1:0] lv, input logic [7:0] sc);
    return ev(0, 0, 1, 0, 0, 0, lv, sc);
  endfunction

  function automatic logic [15:0] hit_v(input bit fl, input logic [1:0] lv, input logic [7:0] sc);
    return ev(0, 0, 0, 0, fl, 0, lv, sc);
  endfunction

  // Push the expectation for the inputs just driven, compare once outputs settle, advance a cycle
  task automatic step(input string tag, input logic [15:0] exp);
    string       t;
    logic [15:0] e;
    logic [15:0] obs;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    #2;
    t   = tag_q.pop_front();
    e   = exp_q.pop_front();
    obs = {UP, DW, leftEN, INIT, flash, game_over, lives, score};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed {UP,DW,leftEN,INIT,flash,go,lives,score}=%h expected %h", t, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  // Walk the 60-frame HIT window; flash starts at 1 and toggles after every 8th frame
  task automatic run_hit(input logic [1:0] lv, input logic [7:0] sc);
    for (int k = 1; k <= 60; k++) begin
      Frame = 1'b1;
      step("hit_frame", hit_v(((k - 1) / 8) % 2 == 0, lv, sc));
      Frame = 1'b0;
      if (k == 60) begin
        collision = 1'b0;
        step("hit_to_respawn", ev(0, 0, 0, 1, 0, 0, lv, sc));
      end else begin
        step("hit_gap", hit_v((k / 8) % 2 == 0, lv, sc));
      end
    end
  endtask

  initial begin
    reset = 1'b1; Frame = 1'b0; start = 1'b0; btnU = 1'b0; btnD = 1'b0;
    collision = 1'b0; SlugH = 15'd100; SlugV = 15'd200;
    repeat (2) @(posedge clk);
    #1;
    step("reset_state", ev(0, 0, 0, 1, 0, 0, 3, 0));
    reset = 1'b0;

    start = 1'b1;  step("idle_start", ev(0, 0, 0, 1, 0, 0, 3, 0));
    start = 1'b0;  step("run_entry", run_v(3, 0));
    SlugV = 15'd16; btnU = 1'b1; step("up_at_top", run_v(3, 0));
    SlugV = 15'd18;              step("up_below_top", ev(1, 0, 1, 0, 0, 0, 3, 0));
    btnD = 1'b1;                 step("both_buttons", run_v(3, 0));
    btnU = 1'b0; SlugV = 15'd464; step("dw_at_bot", run_v(3, 0));
    SlugV = 15'd462;             step("dw_above_bot", ev(0, 1, 1, 0, 0, 0, 3, 0));
    btnD = 1'b0; SlugV = 15'd200; SlugH = 15'd0;
    step("exit_no_frame", run_v(3, 0));
    Frame = 1'b1;  step("exit_frame", run_v(3, 0));
    Frame = 1'b0; SlugH = 15'd100;
    step("respawn", ev(0, 0, 0, 1, 0, 0, 3, 1));
    step("run_after_respawn", run_v(3, 1));

    collision = 1'b1; step("collide_lives3", run_v(3, 1));
    btnU = 1'b1;      step("hit_entry", hit_v(1, 2, 1));
    btnU = 1'b0;
    run_hit(2, 1);
    step("run_after_hit", run_v(2, 1));

    collision = 1'b1; step("collide_lives2", run_v(2, 1));
    step("hit_entry2", hit_v(1, 1, 1));
    run_hit(1, 1);
    step("run_lives1", run_v(1, 1));

    collision = 1'b1; Frame = 1'b1; SlugH = 15'd0;
    step("collide_and_exit", run_v(1, 1));
    collision = 1'b0; Frame = 1'b0; SlugH = 15'd100; btnU = 1'b1;
    step("over", ev(0, 0, 0, 0, 0, 1, 0, 1));
    btnU = 1'b0; start = 1'b1;
    step("over_start", ev(0, 0, 0, 0, 0, 1, 0, 1));
    step("idle_restart", ev(0, 0, 0, 1, 0, 0, 0, 1));
    step("run_restart", run_v(3, 0));

    start = 1'b0; Frame = 1'b1; SlugH = 15'd0;
    step("exit2_frame", run_v(3, 0));
    Frame = 1'b0; SlugH = 15'd100;
    step("respawn2", ev(0, 0, 0, 1, 0, 0, 3, 1));
    step("run2", run_v(3, 1));
    collision = 1'b1; step("collide_r", run_v(3, 1));
    collision = 1'b0; step("hit_r", hit_v(1, 2, 1));
    for (int i = 0; i < 3; i++) begin
      Frame = 1'b1; step("hit_r_frame", hit_v(1, 2, 1));
      Frame = 1'b0; step("hit_r_gap", hit_v(1, 2, 1));
    end
    reset = 1'b1; step("reset_cycle_in_hit", hit_v(1, 2, 1));
    reset = 1'b0; step("reset_to_idle", ev(0, 0, 0, 1, 0, 0, 3, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
